// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM burst reader: FSM encoding and
// output buffer sizing with its pointer helper.
package rom_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int LP_BUF_DEPTH = 3;
   localparam int LP_PTR_W     = $clog2(LP_BUF_DEPTH);
   localparam int LP_CNT_W     = $clog2(LP_BUF_DEPTH + 1);

   // Pointer increment wrapping at the (non power-of-two) buffer depth.
   function automatic logic [LP_PTR_W-1:0] f_ptr_inc(input logic [LP_PTR_W-1:0] i_ptr);
      if (i_ptr == LP_PTR_W'(LP_BUF_DEPTH - 1)) return '0;
      return i_ptr + LP_PTR_W'(1);
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO that holds ROM words while the consumer stalls.
// Head entry is presented combinationally; storage itself is not reset.
module stream_skid_fifo
   import rom_stream_pkg::*;
#(
   parameter int p_WIDTH = 9
) (
   input  logic                i_CLK,
   input  logic                i_RST,
   input  logic                i_PUSH,
   input  logic [p_WIDTH-1:0]  i_DATA,
   input  logic                i_POP,
   output logic [p_WIDTH-1:0]  o_DATA,
   output logic [LP_CNT_W-1:0] o_COUNT
);

   logic [p_WIDTH-1:0]  r_mem [LP_BUF_DEPTH];
   logic [LP_PTR_W-1:0] r_wr_ptr;
   logic [LP_PTR_W-1:0] r_rd_ptr;
   logic [LP_CNT_W-1:0] r_count;
   logic                w_push;
   logic                w_pop;

   assign w_pop  = i_POP && (r_count != '0);
   assign w_push = i_PUSH && ((r_count != LP_CNT_W'(LP_BUF_DEPTH)) || w_pop);

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_W'(1);
            2'b01:   r_count <= r_count - LP_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_CLK) begin
      if (w_push) r_mem[r_wr_ptr] <= i_DATA;
   end

   assign o_DATA  = r_mem[r_rd_ptr];
   assign o_COUNT = r_count;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer in front of a registered ROM: issues reads under a credit
// limit and re-emits the returned words as a valid/ready stream with last.
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int p_ADDRESS_WIDTH = 4,
   parameter int p_DATA_WIDTH    = 8
) (
   input  logic                       i_CLK,
   input  logic                       i_RST,
   input  logic                       i_START,
   input  logic [p_ADDRESS_WIDTH-1:0] i_START_ADDRESS,
   input  logic [p_ADDRESS_WIDTH:0]   i_LENGTH,
   output logic                       o_BUSY,
   output logic                       o_DONE,
   output logic                       o_ROM_READ_ENABLE,
   output logic [p_ADDRESS_WIDTH-1:0] o_ROM_ADDRESS,
   input  logic [p_DATA_WIDTH-1:0]    i_ROM_READ_DATA,
   output logic                       o_VALID,
   output logic [p_DATA_WIDTH-1:0]    o_DATA,
   output logic                       o_LAST,
   input  logic                       i_READY
);

   localparam logic [p_ADDRESS_WIDTH-1:0] LP_ADDR_ONE = 1;
   localparam logic [p_ADDRESS_WIDTH:0]   LP_REM_ONE  = 1;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [p_ADDRESS_WIDTH-1:0]  r_addr;
   logic [p_ADDRESS_WIDTH:0]    r_remaining;
   logic                        r_inflight;
   logic                        r_inflight_last;
   logic                        r_done;
   logic [LP_CNT_W-1:0]         w_count;
   logic [LP_CNT_W:0]           w_outstanding;
   logic [p_DATA_WIDTH:0]       w_head;
   logic                        w_issue;
   logic                        w_valid;
   logic                        w_pop;
   logic                        w_pop_last;
   logic                        w_start_ok;
   logic                        w_start_empty;

   // Credit uses registered state only, so i_READY never reaches the ROM port.
   assign w_outstanding = {1'b0, w_count} + {{LP_CNT_W{1'b0}}, r_inflight};
   assign w_issue       = (r_state == ST_FETCH) && (r_remaining != '0)
                          && (w_outstanding < (LP_CNT_W + 1)'(LP_BUF_DEPTH));
   assign w_valid       = (w_count != '0);
   assign w_pop         = w_valid && i_READY;
   assign w_pop_last    = w_pop && w_head[p_DATA_WIDTH];
   assign w_start_ok    = (r_state == ST_IDLE) && i_START && (i_LENGTH != '0);
   assign w_start_empty = (r_state == ST_IDLE) && i_START && (i_LENGTH == '0);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_next = ST_FETCH;
         ST_FETCH: if (w_issue && (r_remaining == LP_REM_ONE)) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_pop_last) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_remaining == LP_REM_ONE);
         r_done          <= w_start_empty || ((r_state == ST_DRAIN) && w_pop_last);
         if (w_start_ok) begin
            r_addr      <= i_START_ADDRESS;
            r_remaining <= i_LENGTH;
         end else if (w_issue) begin
            r_addr      <= r_addr + LP_ADDR_ONE;
            r_remaining <= r_remaining - LP_REM_ONE;
         end
      end
   end

   // The ROM word lands one cycle after issue; the in-flight flag pushes it.
   stream_skid_fifo #(
      .p_WIDTH (p_DATA_WIDTH + 1)
   ) u_fifo (
      .i_CLK   (i_CLK),
      .i_RST   (i_RST),
      .i_PUSH  (r_inflight),
      .i_DATA  ({r_inflight_last, i_ROM_READ_DATA}),
      .i_POP   (w_pop),
      .o_DATA  (w_head),
      .o_COUNT (w_count)
   );

   assign o_BUSY            = (r_state != ST_IDLE);
   assign o_DONE            = r_done;
   assign o_ROM_READ_ENABLE = w_issue;
   assign o_ROM_ADDRESS     = w_issue ? r_addr : '0;
   assign o_VALID           = w_valid;
   assign o_DATA            = w_valid ? w_head[p_DATA_WIDTH-1:0] : '0;
   assign o_LAST            = w_valid && w_head[p_DATA_WIDTH];

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: registered ROM model plus a burst-level
// reference (expected word queue, outstanding-read count, cycle timing).
module tb_rom_stream_reader;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          i_CLK = 1'b0;
   logic          i_RST;
   logic          i_START;
   logic [AW-1:0] i_START_ADDRESS;
   logic [AW:0]   i_LENGTH;
   logic          o_BUSY;
   logic          o_DONE;
   logic          o_ROM_READ_ENABLE;
   logic [AW-1:0] o_ROM_ADDRESS;
   logic [DW-1:0] i_ROM_READ_DATA;
   logic          o_VALID;
   logic [DW-1:0] o_DATA;
   logic          o_LAST;
   logic          i_READY;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rom_q = '0;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   int            outstanding = 0;
   bit            prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   int            b_addr, b_len, b_issued, b_s, done_cnt, done_cyc, first_cyc;
   bit            b_active = 1'b0;
   logic [DW:0]   exp_q [$];

   rom_stream_reader #(
      .p_ADDRESS_WIDTH (AW),
      .p_DATA_WIDTH    (DW)
   ) dut (
      .i_CLK             (i_CLK),
      .i_RST             (i_RST),
      .i_START           (i_START),
      .i_START_ADDRESS   (i_START_ADDRESS),
      .i_LENGTH          (i_LENGTH),
      .o_BUSY            (o_BUSY),
      .o_DONE            (o_DONE),
      .o_ROM_READ_ENABLE (o_ROM_READ_ENABLE),
      .o_ROM_ADDRESS     (o_ROM_ADDRESS),
      .i_ROM_READ_DATA   (i_ROM_READ_DATA),
      .o_VALID           (o_VALID),
      .o_DATA            (o_DATA),
      .o_LAST            (o_LAST),
      .i_READY           (i_READY)
   );

   always #5 i_CLK = ~i_CLK;

   // Generic synchronous ROM: output register updated only on read enable.
   always @(posedge i_CLK) begin
      if (o_ROM_READ_ENABLE) rom_q <= mem[o_ROM_ADDRESS];
   end
   assign i_ROM_READ_DATA = rom_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(o_BUSY), 0);
      chk({tag, "_done"},  32'(o_DONE), 0);
      chk({tag, "_valid"}, 32'(o_VALID), 0);
      chk({tag, "_last"},  32'(o_LAST), 0);
      chk({tag, "_rden"},  32'(o_ROM_READ_ENABLE), 0);
      chk({tag, "_data"},  32'(o_DATA), 0);
      chk({tag, "_addr"},  32'(o_ROM_ADDRESS), 0);
   endtask

   // Observe the current cycle against the reference, then advance one clock.
   task automatic tick();
      logic [DW:0] e;
      if (!o_VALID) begin
         chk("data_zero_when_idle", 32'(o_DATA), 0);
         chk("last_zero_when_idle", 32'(o_LAST), 0);
      end
      if (prev_hold) begin
         chk("hold_valid", 32'(o_VALID), 1);
         chk("hold_data",  32'(o_DATA), 32'(prev_data));
         chk("hold_last",  32'(o_LAST), 32'(prev_last));
      end
      if (o_ROM_READ_ENABLE) begin
         if (!b_active) chk("spurious_read", 32'(o_ROM_READ_ENABLE), 0);
         else begin
            chk("credit_limit", 32'(outstanding < 3), 1);
            chk("rom_addr", 32'(o_ROM_ADDRESS), 32'((b_addr + b_issued) % DEPTH));
            b_issued++;
         end
      end
      if (o_VALID && i_READY) begin
         if (exp_q.size() == 0) chk("extra_word", 32'(o_VALID), 0);
         else begin
            e = exp_q.pop_front();
            chk("word_data", 32'(o_DATA), 32'(e[DW-1:0]));
            chk("word_last", 32'(o_LAST), 32'(e[DW]));
            if (first_cyc < 0) first_cyc = cyc;
         end
      end
      if (o_DONE) begin
         done_cnt++;
         done_cyc = cyc;
         chk("busy_at_done", 32'(o_BUSY), 0);
      end else if (b_active && cyc > b_s && b_len > 0 && done_cnt == 0) begin
         chk("busy_during_burst", 32'(o_BUSY), 1);
      end
      outstanding += int'(o_ROM_READ_ENABLE);
      if (o_VALID && i_READY) outstanding--;
      prev_hold = o_VALID && !i_READY;
      prev_data = o_DATA;
      prev_last = o_LAST;
      @(posedge i_CLK);
      #1;
      cyc++;
   endtask

   task automatic begin_burst(input int addr, input int len);
      exp_q.delete();
      for (int i = 0; i < len; i++)
         exp_q.push_back({(i == len - 1), mem[(addr + i) % DEPTH]});
      b_addr    = addr;
      b_len     = len;
      b_issued  = 0;
      done_cnt  = 0;
      done_cyc  = -1;
      first_cyc = -1;
      b_s       = cyc;
      b_active  = 1'b1;
      i_START         = 1'b1;
      i_START_ADDRESS = AW'(addr);
      i_LENGTH        = (AW + 1)'(len);
      i_READY         = 1'b1;
      tick();
      i_START = 1'b0;
   endtask

   // rmode: 0 ready high, 1 one-high/two-low, 2 random ready.
   task automatic run_burst(input int addr, input int len, input int rmode, input bit inject);
      begin_burst(addr, len);
      for (int k = 0; k < 400 && done_cnt == 0; k++) begin
         case (rmode)
            0:       i_READY = 1'b1;
            1:       i_READY = (k % 3 == 0);
            default: i_READY = 1'($urandom_range(0, 1));
         endcase
         if (inject && k == 2) begin
            i_START         = 1'b1;
            i_START_ADDRESS = AW'(addr + 7);
            i_LENGTH        = (AW + 1)'(3);
         end else begin
            i_START = 1'b0;
         end
         tick();
      end
      i_START = 1'b0;
      chk("done_pulse_count", 32'(done_cnt), 1);
      chk("words_remaining", 32'(exp_q.size()), 0);
      chk("reads_issued", 32'(b_issued), 32'(len));
      if (rmode == 0) begin
         chk("done_cycle", 32'(done_cyc - b_s), 32'((len == 0) ? 1 : len + 3));
         if (len > 0) chk("first_valid_cycle", 32'(first_cyc - b_s), 3);
      end
      b_active = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 8'h10);
      i_RST = 1'b1;
      i_START = 1'b0;
      i_START_ADDRESS = '0;
      i_LENGTH = '0;
      i_READY = 1'b0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(posedge i_CLK);
      #1;
      i_RST = 1'b0;

      run_burst(2, 4, 0, 1'b0);
      run_burst(14, 4, 0, 1'b0);
      run_burst(0, 6, 1, 1'b0);
      run_burst(9, 0, 0, 1'b0);
      run_burst(7, 16, 0, 1'b0);
      run_burst(4, 5, 0, 1'b1);

      // Reset one cycle after the first read issue; that word must vanish.
      begin_burst(3, 8);
      chk("issue_before_reset", 32'(o_ROM_READ_ENABLE), 1);
      tick();
      i_RST = 1'b1;
      #1;
      chk_all_zero("midburst_reset");
      exp_q.delete();
      outstanding = 0;
      prev_hold   = 1'b0;
      b_active    = 1'b0;
      tick();
      i_RST = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("post_reset_valid", 32'(o_VALID), 0);
         tick();
      end
      run_burst(5, 2, 0, 1'b0);

      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      for (int r = 0; r < 25; r++)
         run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
